fault_response_monitor: RTL and testbench
=========================================

Name: fault_response_monitor

Overview:
- Sits directly downstream of the fault-injected sqrt netlist (64-bit asqrt output) in the hardware fault-campaign flow.
- Consumes one output sample per stimulus step. On a fault-free golden pass it stores the per-step reference vectors and a MISR signature.
- On each faulty pass it compares step by step against the golden vectors and reports per-fault-ID detection, first failing step, signature and a running detected-fault count.
- Replaces the text-log-and-diff post-processing of per-step output dumps.

Parameters:
- OUT_W, 64, width of the DUT output sample (asqrt).
- STEPS, 128, stimulus steps per pass; must be a power of two, at most 256.
- FID_W, 16, fault ID width (covers 49108 faults).
- MISR_W, 32, signature width; OUT_W must be a multiple of MISR_W.
- MISR_POLY, 32'h04C11DB7, MISR feedback polynomial.
- MISR_SEED, 32'hFFFFFFFF, signature value at start of every pass.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a pass.
- golden_mode  in  1  sampled with start; 1 = fault-free reference pass.
- fid_in  in  FID_W  fault ID of the pass, sampled with start.
- sample_valid  in  1  sample_data holds one step's DUT output.
- sample_data  in  OUT_W  DUT output for the current step.
- busy  out  1  pass in progress (RUN/CMP/REPORT).
- golden_ok  out  1  a complete golden pass is stored.
- done_valid  out  1  one-cycle pulse: pass result is valid.
- done_fid  out  FID_W  fault ID of the reported pass.
- detected  out  1  at least one step mismatched golden (always 0 for golden passes).
- first_fail_step  out  8  index of the first mismatching step; 8'hFF if none.
- signature  out  MISR_W  final MISR value of the pass.
- sig_alias  out  1  detected=1 but signature equals the golden signature.
- det_count  out  FID_W  detected faults since reset; saturates at all-ones.
- err_protocol  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (async assert, sync release): FSM to IDLE; all outputs 0 except first_fail_step=8'hFF and signature=MISR_SEED; golden_ok cleared. The golden store contents are don't-care after reset.
- FSM states:
  - IDLE: start moves to RUN; step_cnt=0, sig=MISR_SEED, mismatch flag cleared, fid and mode latched.
  - RUN: each sample_valid updates the MISR and increments step_cnt. After sample STEPS-1 is accepted, go to CMP.
  - CMP: one cycle; compute sig_alias and update det_count.
  - REPORT: done_valid=1 for one cycle, then IDLE.
- Latency: done_valid is asserted exactly 2 cycles after the clock edge that accepts the last sample.
- Golden pass:
  - Writes sample_data to golden[step_cnt].
  - At REPORT, the final signature goes to golden_sig and golden_ok is set.
  - detected=0; det_count is unchanged.
- Faulty pass:
  - Compares sample_data with golden[step_cnt] on every accepted sample.
  - On the first mismatch, first_fail_step is set to step_cnt.
  - Faulty passes never modify golden contents.
- MISR update: fold = XOR of the OUT_W/MISR_W slices of sample_data; sig_next = (sig<<1) ^ (sig[MSB] ? MISR_POLY : 0) ^ fold.
- Outputs done_fid, detected, first_fail_step, signature and sig_alias hold their values from REPORT until the next REPORT.
- Protocol violations (each sets err_protocol, sticky until reset):
  - start while busy: the start is ignored.
  - sample_valid in IDLE/CMP/REPORT: the sample is ignored.
  - start with golden_mode=0 while golden_ok=0: the pass runs, and detected reports 0.
- Simultaneous start and last sample: start is ignored with an error, as above.
- Gaps in sample_valid are legal; step_cnt advances only on accepted samples.
- A golden pass started while golden_ok=1 overwrites the store. golden_ok drops at its start and rises at its REPORT.
- Reset mid-pass aborts the pass with no done_valid.

Decomposition:
- Shared package fault_campaign_pkg:
  - FSM state enum.
  - MISR_POLY and MISR_SEED defaults.
  - Width constants for FID and step index.
  - Fault-result struct {fid, detected, first_fail_step, signature}.
- One sub-module, misr_compactor: parameterised fold plus LFSR update, with seed-load and enable inputs. The golden store is an inferred STEPS x OUT_W array inside the top module.

Test Plan:
- Golden pass with samples = step index (0..127) -> done_valid 2 cycles after step 127; golden_ok=1; detected=0; first_fail_step=8'hFF; det_count=0.
- Faulty pass, fid 5, identical data -> detected=0; signature equals golden_sig; sig_alias=0; det_count=0.
- Faulty pass, fid 7, bit 0 of step 42 flipped -> detected=1; first_fail_step=42; done_fid=7; det_count=1; signature differs from golden_sig.
- Start during RUN, sample_valid in IDLE, and a faulty start before any golden pass -> each sets err_protocol; the running pass's result is unchanged.
- Reset asserted at step 60 of a faulty pass, then start of a faulty pass -> no done_valid for the aborted pass; golden_ok=0 and err_protocol=1 after the new start.
- Sample stream with sample_valid low every other cycle -> same result as the gapless run; latency is measured from the last accepted sample.

Source files
------------

// File: rtl/fault_campaign_pkg.sv
// Shared types and constants for the fault-campaign response monitor.
// Holds the FSM encoding, MISR defaults, index widths and the per-fault result record.
package fault_campaign_pkg;

  localparam int FID_W_DEF = 16;
  localparam int STEP_W    = 8;
  localparam int MISR_W_DEF = 32;

  localparam logic [MISR_W_DEF-1:0] MISR_POLY_DEF = 32'h04C11DB7;
  localparam logic [MISR_W_DEF-1:0] MISR_SEED_DEF = 32'hFFFFFFFF;
  localparam logic [STEP_W-1:0]     NO_FAIL_STEP  = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_CMP,
    S_REPORT
  } mon_state_e;

  typedef struct packed {
    logic [FID_W_DEF-1:0]  fid;
    logic                  detected;
    logic [STEP_W-1:0]     first_fail_step;
    logic [MISR_W_DEF-1:0] signature;
  } fault_result_t;

endpackage

// File: rtl/fault_response_monitor_if.sv
// Sample stream, pass control and result bus of the fault response monitor.
// master = stimulus side (netlist harness), slave = the monitor itself.
interface fault_response_monitor_if
  import fault_campaign_pkg::*;
#(
  parameter int OUT_W  = 64,
  parameter int FID_W  = FID_W_DEF,
  parameter int MISR_W = MISR_W_DEF
);

  logic              start;
  logic              golden_mode;
  logic [FID_W-1:0]  fid_in;
  logic              sample_valid;
  logic [OUT_W-1:0]  sample_data;

  logic              busy;
  logic              golden_ok;
  logic              done_valid;
  logic [FID_W-1:0]  done_fid;
  logic              detected;
  logic [STEP_W-1:0] first_fail_step;
  logic [MISR_W-1:0] signature;
  logic              sig_alias;
  logic [FID_W-1:0]  det_count;
  logic              err_protocol;

  modport master (
    output start, golden_mode, fid_in, sample_valid, sample_data,
    input  busy, golden_ok, done_valid, done_fid, detected, first_fail_step,
           signature, sig_alias, det_count, err_protocol
  );

  modport slave (
    input  start, golden_mode, fid_in, sample_valid, sample_data,
    output busy, golden_ok, done_valid, done_fid, detected, first_fail_step,
           signature, sig_alias, det_count, err_protocol
  );

endinterface

// File: rtl/misr_compactor.sv
// Multiple-input signature register: XOR-folds a wide sample down to MISR_W bits
// and merges it into a Galois-style LFSR. load re-seeds, en advances one step.
module misr_compactor
  import fault_campaign_pkg::*;
#(
  parameter int                OUT_W  = 64,
  parameter int                MISR_W = MISR_W_DEF,
  parameter logic [MISR_W-1:0] POLY   = MISR_POLY_DEF,
  parameter logic [MISR_W-1:0] SEED   = MISR_SEED_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              en,
  input  logic [OUT_W-1:0]  data,
  output logic [MISR_W-1:0] sig
);

  localparam int SLICES = OUT_W / MISR_W;

  logic [MISR_W-1:0] fold;
  logic [MISR_W-1:0] sig_next;

  // NOTE: always_comb uses blocking '=' and assigns a default first, so the
  // running XOR accumulates within the loop and no latch can be inferred.
  always_comb begin
    fold = '0;
    for (int i = 0; i < SLICES; i++) begin
      fold = fold ^ data[i*MISR_W +: MISR_W];
    end
  end

  assign sig_next = {sig[MISR_W-2:0], 1'b0} ^ (sig[MISR_W-1] ? POLY : '0) ^ fold;

  // NOTE: sequential state uses non-blocking '<=' so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/fault_response_monitor.sv
// Per-step golden/faulty comparator with MISR signature for fault campaigns.
// A golden pass fills the reference store; faulty passes compare against it.
module fault_response_monitor
  import fault_campaign_pkg::*;
#(
  parameter int                OUT_W     = 64,
  parameter int                STEPS     = 128,
  parameter int                FID_W     = FID_W_DEF,
  parameter int                MISR_W    = MISR_W_DEF,
  parameter logic [MISR_W-1:0] MISR_POLY = MISR_POLY_DEF,
  parameter logic [MISR_W-1:0] MISR_SEED = MISR_SEED_DEF
) (
  input  logic clk,
  input  logic rst_n,
  fault_response_monitor_if.slave bus
);

  localparam int IDX_W = $clog2(STEPS);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  mon_state_e        state;
  logic [STEP_W-1:0] step_cnt;
  logic              mode_golden;
  logic              no_ref;
  logic              mismatch;
  logic [STEP_W-1:0] fail_step;
  logic [FID_W-1:0]  fid_q;
  logic [MISR_W-1:0] golden_sig;
  logic [MISR_W-1:0] sig;
  logic [OUT_W-1:0]  golden [STEPS];

  logic             start_ok;
  logic             accept;
  logic             miscompare;
  logic             protocol_err;
  logic [IDX_W-1:0] idx;

  assign idx        = step_cnt[IDX_W-1:0];
  assign start_ok   = bus.start && (state == S_IDLE);
  assign accept     = bus.sample_valid && (state == S_RUN);
  assign miscompare = !mode_golden && !no_ref && (bus.sample_data != golden[idx]);

  // Faulty start without a stored reference still runs, but is flagged.
  assign protocol_err = (bus.start && (state != S_IDLE))
                     || (bus.sample_valid && (state != S_RUN))
                     || (start_ok && !bus.golden_mode && !bus.golden_ok);

  misr_compactor #(
    .OUT_W (OUT_W),
    .MISR_W(MISR_W),
    .POLY  (MISR_POLY),
    .SEED  (MISR_SEED)
  ) u_misr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (start_ok),
    .en   (accept),
    .data (bus.sample_data),
    .sig  (sig)
  );

  // NOTE: the golden store has no reset; its contents are only trusted once
  // golden_ok is set, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (accept && mode_golden) begin
      golden[idx] <= bus.sample_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= S_IDLE;
      step_cnt            <= '0;
      mode_golden         <= 1'b0;
      no_ref              <= 1'b0;
      mismatch            <= 1'b0;
      fail_step           <= NO_FAIL_STEP;
      fid_q               <= '0;
      golden_sig          <= MISR_SEED;
      bus.busy            <= 1'b0;
      bus.golden_ok       <= 1'b0;
      bus.done_valid      <= 1'b0;
      bus.done_fid        <= '0;
      bus.detected        <= 1'b0;
      bus.first_fail_step <= NO_FAIL_STEP;
      bus.signature       <= MISR_SEED;
      bus.sig_alias       <= 1'b0;
      bus.det_count       <= '0;
      bus.err_protocol    <= 1'b0;
    end else begin
      bus.done_valid <= 1'b0;
      if (protocol_err) begin
        bus.err_protocol <= 1'b1;
      end

      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            state       <= S_RUN;
            step_cnt    <= '0;
            mismatch    <= 1'b0;
            fail_step   <= NO_FAIL_STEP;
            fid_q       <= bus.fid_in;
            mode_golden <= bus.golden_mode;
            no_ref      <= !bus.golden_mode && !bus.golden_ok;
            bus.busy    <= 1'b1;
            if (bus.golden_mode) begin
              bus.golden_ok <= 1'b0;
            end
          end
        end

        S_RUN: begin
          if (bus.sample_valid) begin
            step_cnt <= step_cnt + STEP_W'(1);
            if (miscompare && !mismatch) begin
              mismatch  <= 1'b1;
              fail_step <= step_cnt;
            end
            if (step_cnt == LAST_STEP) begin
              state <= S_CMP;
            end
          end
        end

        S_CMP: begin
          state               <= S_REPORT;
          bus.done_valid      <= 1'b1;
          bus.done_fid        <= fid_q;
          bus.detected        <= mismatch;
          bus.first_fail_step <= fail_step;
          bus.signature       <= sig;
          bus.sig_alias       <= mismatch && (sig == golden_sig);
          if (mismatch && (bus.det_count != '1)) begin
            bus.det_count <= bus.det_count + FID_W'(1);
          end
          if (mode_golden) begin
            golden_sig    <= sig;
            bus.golden_ok <= 1'b1;
          end
        end

        S_REPORT: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fault_response_monitor.sv
// Randomised scoreboard bench for fault_response_monitor: a driver pushes the
// expected pass result from a high-level model, a negedge monitor pops and compares.
module tb_fault_response_monitor;
  import fault_campaign_pkg::*;

  localparam int OUT_W = 64;
  localparam int STEPS = 128;
  localparam int FID_W = 16;

  typedef struct {
    fault_result_t res;
    logic          alias_flag;
    logic [15:0]   dcnt;
    logic          gok;
    int            at_neg;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fault_response_monitor_if #(.OUT_W(OUT_W), .FID_W(FID_W), .MISR_W(32)) bus ();

  fault_response_monitor #(
    .OUT_W(OUT_W), .STEPS(STEPS), .FID_W(FID_W), .MISR_W(32),
    .MISR_POLY(32'h04C11DB7), .MISR_SEED(32'hFFFFFFFF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int neg_cnt = 0;
  exp_t sb[$];

  logic [63:0] m_golden [STEPS];
  logic [63:0] pass_data [STEPS];
  logic [31:0] m_golden_sig;
  bit          m_golden_ok;
  bit          m_err;
  logic [15:0] m_det;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: spec-level arithmetic over the whole sample vector.
  task automatic model_pass(input bit gm, input logic [15:0] fid, output exp_t e);
    logic [31:0] s;
    logic [31:0] fold;
    s = 32'hFFFFFFFF;
    e.res.fid = fid;
    e.res.detected = 1'b0;
    e.res.first_fail_step = 8'hFF;
    for (int i = 0; i < STEPS; i++) begin
      fold = pass_data[i][31:0] ^ pass_data[i][63:32];
      s = (s << 1) ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ fold;
      if (!gm && m_golden_ok && !e.res.detected && pass_data[i] != m_golden[i]) begin
        e.res.detected = 1'b1;
        e.res.first_fail_step = 8'(i);
      end
    end
    e.res.signature = s;
    e.alias_flag = e.res.detected && (s == m_golden_sig);
    if (gm) begin
      for (int i = 0; i < STEPS; i++) m_golden[i] = pass_data[i];
      m_golden_sig = s;
      m_golden_ok = 1'b1;
    end
    if (e.res.detected && m_det != 16'hFFFF) m_det = m_det + 16'd1;
    e.dcnt = m_det;
    e.gok = m_golden_ok;
  endtask

  task automatic drive_idle();
    bus.start = 1'b0;
    bus.golden_mode = 1'b0;
    bus.fid_in = '0;
    bus.sample_valid = 1'b0;
    bus.sample_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    m_golden_ok = 1'b0;
    m_err = 1'b0;
    m_det = '0;
    rst_n = 1'b1;
  endtask

  // gap: 0 none, 1 every other cycle idle, 2 random idle cycles.
  // spurious: inject ignored starts mid-pass and together with the last sample.
  task automatic run_pass(input bit gm, input logic [15:0] fid, input int gap,
                          input int abort_at, input bit spurious);
    exp_t e;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.golden_mode = gm;
    bus.fid_in = fid;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (gm) m_golden_ok = 1'b0;
    if (!gm && !m_golden_ok) m_err = 1'b1;
    check("err_after_start", bus.err_protocol, m_err);
    check("golden_ok_after_start", bus.golden_ok, m_golden_ok);
    check("busy_after_start", bus.busy, 1);
    for (int s = 0; s < STEPS; s++) begin
      if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) begin
        bus.sample_valid = 1'b0;
        bus.sample_data = 64'($urandom);
        repeat ((gap == 2) ? $urandom_range(1, 3) : 1) @(posedge clk);
        #1;
      end
      if (s == abort_at) begin
        do_reset();
        return;
      end
      bus.sample_valid = 1'b1;
      bus.sample_data = pass_data[s];
      if (spurious && (s == 10 || s == STEPS - 1)) begin
        bus.start = 1'b1;
        bus.golden_mode = 1'b1;
        bus.fid_in = ~fid;
        m_err = 1'b1;
      end
      if (s == STEPS - 1) begin
        model_pass(gm, fid, e);
        e.at_neg = neg_cnt + 3;
        sb.push_back(e);
      end
      @(posedge clk); #1;
      bus.sample_valid = 1'b0;
      bus.start = 1'b0;
    end
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    check("done_timeout", 64'(sb.size()), 0);
    #1;
    check("busy_after_pass", bus.busy, 0);
    check("err_after_pass", bus.err_protocol, m_err);
  endtask

  task automatic fill_index();
    for (int i = 0; i < STEPS; i++) pass_data[i] = 64'(i);
  endtask

  task automatic fill_faulty(input int flips);
    for (int i = 0; i < STEPS; i++) pass_data[i] = m_golden[i];
    for (int f = 0; f < flips; f++) begin
      int st;
      int bt;
      st = $urandom_range(0, STEPS - 1);
      bt = $urandom_range(0, 63);
      pass_data[st][bt] = ~pass_data[st][bt];
    end
  endtask

  // Monitor: compares every presented result against the scoreboard head.
  bit prev_done = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      neg_cnt++;
      if (bus.done_valid) begin
        if (prev_done) check("done_pulse_width", bus.done_valid, 0);
        if (sb.size() == 0) begin
          check("done_unexpected", bus.done_valid, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_fid", bus.done_fid, e.res.fid);
          check("detected", bus.detected, e.res.detected);
          check("first_fail_step", bus.first_fail_step, e.res.first_fail_step);
          check("signature", bus.signature, e.res.signature);
          check("sig_alias", bus.sig_alias, e.alias_flag);
          check("det_count", bus.det_count, e.dcnt);
          check("golden_ok_at_done", bus.golden_ok, e.gok);
          check("done_latency", 64'(neg_cnt), 64'(e.at_neg));
        end
      end
      prev_done = bus.done_valid;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    drive_idle();
    m_golden_sig = 32'hFFFFFFFF;
    do_reset();
    check("rst_busy", bus.busy, 0);
    check("rst_golden_ok", bus.golden_ok, 0);
    check("rst_done_valid", bus.done_valid, 0);
    check("rst_done_fid", bus.done_fid, 0);
    check("rst_detected", bus.detected, 0);
    check("rst_first_fail_step", bus.first_fail_step, 8'hFF);
    check("rst_signature", bus.signature, 32'hFFFFFFFF);
    check("rst_sig_alias", bus.sig_alias, 0);
    check("rst_det_count", bus.det_count, 0);
    check("rst_err_protocol", bus.err_protocol, 0);

    // Golden pass with sample = step index.
    fill_index();
    run_pass(1'b1, 16'd1, 0, -1, 1'b0);
    check("golden_ok_set", bus.golden_ok, 1);

    // Identical data, then a single flipped bit at step 42, gapless and gapped.
    fill_index();
    run_pass(1'b0, 16'd5, 0, -1, 1'b0);
    pass_data[42][0] = ~pass_data[42][0];
    run_pass(1'b0, 16'd7, 0, -1, 1'b0);
    run_pass(1'b0, 16'd7, 1, -1, 1'b0);

    repeat (5) begin
      fill_faulty($urandom_range(0, 3));
      run_pass(1'b0, 16'($urandom), 2, -1, 1'b0);
    end

    // Overwrite the store with a random golden pass, then compare against it.
    for (int i = 0; i < STEPS; i++) pass_data[i] = {$urandom, $urandom};
    run_pass(1'b1, 16'($urandom), 2, -1, 1'b0);
    repeat (4) begin
      fill_faulty($urandom_range(0, 2));
      run_pass(1'b0, 16'($urandom), $urandom_range(0, 2), -1, 1'b0);
    end

    // Sample while idle is ignored but flagged.
    check("err_before_idle_sample", bus.err_protocol, m_err);
    @(posedge clk); #1;
    bus.sample_valid = 1'b1;
    bus.sample_data = {$urandom, $urandom};
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    m_err = 1'b1;
    check("err_idle_sample", bus.err_protocol, m_err);
    fill_faulty(1);
    run_pass(1'b0, 16'h00AA, 0, -1, 1'b0);

    // Fresh golden, then a pass disturbed by ignored starts.
    do_reset();
    check("rst2_golden_ok", bus.golden_ok, 0);
    check("rst2_err", bus.err_protocol, 0);
    check("rst2_det_count", bus.det_count, 0);
    fill_index();
    run_pass(1'b1, 16'd2, 0, -1, 1'b0);
    fill_faulty(2);
    run_pass(1'b0, 16'd9, 0, -1, 1'b1);

    // Reset at step 60 aborts the pass; next faulty start has no reference.
    fill_faulty(1);
    run_pass(1'b0, 16'd11, 0, 60, 1'b0);
    check("abort_golden_ok", bus.golden_ok, 0);
    check("abort_done_valid", bus.done_valid, 0);
    fill_faulty(3);
    run_pass(1'b0, 16'd12, 0, -1, 1'b0);

    repeat (5) @(posedge clk);
    check("scoreboard_empty", 64'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
